// File: rtl/gear_fifo_if.sv
// Bus bundle between the chunk writer / CPU reader and gear_fifo.
// The FIFO takes the slave view; the traffic source takes the master view.
interface gear_fifo_if #(
    parameter int IN_WIDTH   = 1,
    parameter int OUT_WIDTH  = 8,
    parameter int DEPTH_LOG2 = 7
);
    localparam int RATIO       = OUT_WIDTH / IN_WIDTH;
    localparam int COUNT_WIDTH = $clog2(RATIO + 1);

    logic                   inClear;
    logic                   inWriteEnable;
    logic [IN_WIDTH-1:0]    inData;
    logic                   inPadFlush;
    logic                   inReadEnable;
    logic                   inClearErrors;

    logic [OUT_WIDTH-1:0]   outData;
    logic                   outReadValid;
    logic                   outReadReady;
    logic [DEPTH_LOG2:0]    outLevel;
    logic [COUNT_WIDTH-1:0] outPartialCount;
    logic                   outFull;
    logic                   outEmpty;
    logic                   outAlmostFull;
    logic                   outAlmostEmpty;
    logic                   outWriteError;
    logic                   outReadError;

    modport slave (
        input  inClear, inWriteEnable, inData, inPadFlush, inReadEnable, inClearErrors,
        output outData, outReadValid, outReadReady, outLevel, outPartialCount,
               outFull, outEmpty, outAlmostFull, outAlmostEmpty,
               outWriteError, outReadError
    );

    modport master (
        output inClear, inWriteEnable, inData, inPadFlush, inReadEnable, inClearErrors,
        input  outData, outReadValid, outReadReady, outLevel, outPartialCount,
               outFull, outEmpty, outAlmostFull, outAlmostEmpty,
               outWriteError, outReadError
    );
endinterface

// File: rtl/gear_fifo.sv
// Width-converting FIFO: packs IN_WIDTH-bit chunks into OUT_WIDTH-bit words,
// stores them, and returns them through a three-state registered read port.
module gear_fifo #(
    parameter int IN_WIDTH           = 1,
    parameter int OUT_WIDTH          = 8,
    parameter int DEPTH_LOG2         = 7,
    parameter int ALMOST_EMPTY_LEVEL = (2 ** DEPTH_LOG2) / 4,
    parameter int ALMOST_FULL_LEVEL  = 3 * (2 ** DEPTH_LOG2) / 4,
    parameter bit MSB_FIRST          = 1'b1,
    parameter bit EDGE_MODE          = 1'b1
) (
    input logic        inClock,
    input logic        inReset,
    gear_fifo_if.slave bus
);
    localparam int RATIO       = OUT_WIDTH / IN_WIDTH;
    localparam int DEPTH       = 2 ** DEPTH_LOG2;
    localparam int COUNT_WIDTH = $clog2(RATIO + 1);
    localparam int LEVEL_WIDTH = DEPTH_LOG2 + 1;

    localparam logic [COUNT_WIDTH-1:0] LAST_SLOT  = COUNT_WIDTH'(RATIO - 1);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);

    if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 2) begin : gBadRatio
        $error("gear_fifo: OUT_WIDTH must be a multiple of IN_WIDTH with a ratio of at least 2");
    end

    typedef enum logic [1:0] {
        RIDLE,
        RFETCH,
        RVALID
    } readState_e;

    // Registered state
    readState_e             state;
    logic                   writeEnableQ;
    logic                   readEnableQ;
    logic [COUNT_WIDTH-1:0] partialCount;
    logic [OUT_WIDTH-1:0]   assembly;
    logic [DEPTH_LOG2-1:0]  wrPtr;
    logic [DEPTH_LOG2-1:0]  rdPtr;
    logic [LEVEL_WIDTH-1:0] level;
    logic [OUT_WIDTH-1:0]   dataOut;
    logic                   readValid;
    logic                   readReady;
    logic                   writeError;
    logic                   readError;

    logic [OUT_WIDTH-1:0]   mem [DEPTH];
    logic [OUT_WIDTH-1:0]   headWord;

    // Per-cycle decisions
    logic                   writeRequest;
    logic                   readRequest;
    logic                   isFull;
    logic                   hasRoom;
    logic                   readAccept;
    logic                   readReject;
    logic                   completesWord;
    logic                   writeAccept;
    logic                   writeReject;
    logic                   wordCommit;
    logic                   flushWanted;
    logic                   flushCommit;
    logic                   flushReject;
    logic                   commit;
    logic [COUNT_WIDTH-1:0] countAfterWrite;
    logic [OUT_WIDTH-1:0]   assemblyNext;
    int                     shiftAmount;

    assign writeRequest = EDGE_MODE ? (bus.inWriteEnable & ~writeEnableQ) : bus.inWriteEnable;
    assign readRequest  = EDGE_MODE ? (bus.inReadEnable  & ~readEnableQ)  : bus.inReadEnable;

    // Accept/reject decisions, chunk placement and commit selection for this cycle.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
        isFull          = (level == FULL_LEVEL);
        readAccept      = (state == RIDLE) && readRequest && (level != '0);
        readReject      = readRequest && (((state == RIDLE) && (level == '0)) ||
                                          ((state != RIDLE) && EDGE_MODE));
        // A read leaving in the same cycle frees the slot a commit needs.
        hasRoom         = !isFull || readAccept;
        completesWord   = writeRequest && (partialCount == LAST_SLOT);
        writeReject     = completesWord && !hasRoom;
        writeAccept     = writeRequest && !writeReject;

        shiftAmount     = MSB_FIRST ? (RATIO - 1 - int'(partialCount)) * IN_WIDTH
                                    : int'(partialCount) * IN_WIDTH;
        // Unused slots of the assembly register are always zero, so OR-ing places the chunk.
        assemblyNext    = assembly;
        countAfterWrite = partialCount;
        if (writeAccept) begin
            assemblyNext    = assembly | (OUT_WIDTH'(bus.inData) << shiftAmount);
            countAfterWrite = partialCount + COUNT_WIDTH'(1);
        end

        wordCommit  = writeAccept && completesWord;
        // Only a still-partial word can be flushed; a completed word already commits itself.
        flushWanted = bus.inPadFlush && !wordCommit && (countAfterWrite != '0);
        flushCommit = flushWanted && hasRoom;
        flushReject = flushWanted && !hasRoom;
        commit      = wordCommit || flushCommit;
    end

    // Word storage and head capture; the head word is taken at the accept edge so a
    // commit into the slot being freed on a full FIFO cannot overwrite it.
    always_ff @(posedge inClock) begin
        // NOTE: the array has no reset: every entry is written before it can be read,
        // and leaving it unreset lets it map onto plain RAM.
        if (commit && !inReset && !bus.inClear) begin
            mem[wrPtr] <= assemblyNext;
        end
        if (readAccept) begin
            headWord <= mem[rdPtr];
        end
    end

    // Control state: edge detectors, assembly, pointers, level, sticky errors and read FSM.
    always_ff @(posedge inClock) begin
        // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
        if (inReset || bus.inClear) begin
            state        <= RIDLE;
            writeEnableQ <= 1'b0;
            readEnableQ  <= 1'b0;
            partialCount <= '0;
            assembly     <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            level        <= '0;
            dataOut      <= '0;
            readValid    <= 1'b0;
            readReady    <= 1'b1;
            writeError   <= 1'b0;
            readError    <= 1'b0;
        end else begin
            writeEnableQ <= bus.inWriteEnable;
            readEnableQ  <= bus.inReadEnable;

            if (commit) begin
                wrPtr        <= wrPtr + 1'b1;
                partialCount <= '0;
                assembly     <= '0;
            end else begin
                partialCount <= countAfterWrite;
                assembly     <= assemblyNext;
            end

            if (readAccept) begin
                rdPtr <= rdPtr + 1'b1;
            end
            level <= level + LEVEL_WIDTH'(commit) - LEVEL_WIDTH'(readAccept);

            // An error event in the same cycle as a clear request wins.
            if (writeReject || flushReject) begin
                writeError <= 1'b1;
            end else if (bus.inClearErrors) begin
                writeError <= 1'b0;
            end
            if (readReject) begin
                readError <= 1'b1;
            end else if (bus.inClearErrors) begin
                readError <= 1'b0;
            end

            case (state)
                RIDLE: begin
                    if (readAccept) begin
                        state     <= RFETCH;
                        readReady <= 1'b0;
                    end
                end
                RFETCH: begin
                    dataOut   <= headWord;
                    readValid <= 1'b1;
                    state     <= RVALID;
                end
                RVALID: begin
                    readValid <= 1'b0;
                    readReady <= 1'b1;
                    state     <= RIDLE;
                end
                default: begin
                    readValid <= 1'b0;
                    readReady <= 1'b1;
                    state     <= RIDLE;
                end
            endcase
        end
    end

    assign bus.outData         = dataOut;
    assign bus.outReadValid    = readValid;
    assign bus.outReadReady    = readReady;
    assign bus.outLevel        = level;
    assign bus.outPartialCount = partialCount;
    assign bus.outFull         = (level == FULL_LEVEL);
    assign bus.outEmpty        = (level == '0);
    assign bus.outAlmostFull   = (level >= LEVEL_WIDTH'(ALMOST_FULL_LEVEL));
    assign bus.outAlmostEmpty  = (level <= LEVEL_WIDTH'(ALMOST_EMPTY_LEVEL));
    assign bus.outWriteError   = writeError;
    assign bus.outReadError    = readError;
endmodule

// File: tb/tb_gear_fifo.sv
// Directed bench for gear_fifo. Four instances share one stimulus bus:
//   dutA MSB-first level mode, dutB LSB-first level mode,
//   dutC DEPTH_LOG2 = 2 level mode, dutD MSB-first edge mode.
// Each scenario starts from a reset, so only the instance under test matters.
module tb_gear_fifo;
    logic inClock = 1'b0;
    logic inReset = 1'b1;
    logic clear   = 1'b0;
    logic we      = 1'b0;
    logic data    = 1'b0;
    logic flush   = 1'b0;
    logic re      = 1'b0;
    logic clrErr  = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    always #10 inClock = ~inClock;

    gear_fifo_if #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(7)) ifA ();
    gear_fifo_if #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(7)) ifB ();
    gear_fifo_if #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(2)) ifC ();
    gear_fifo_if #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(7)) ifD ();

    assign {ifA.inClear, ifA.inWriteEnable, ifA.inData, ifA.inPadFlush, ifA.inReadEnable, ifA.inClearErrors} = {clear, we, data, flush, re, clrErr};
    assign {ifB.inClear, ifB.inWriteEnable, ifB.inData, ifB.inPadFlush, ifB.inReadEnable, ifB.inClearErrors} = {clear, we, data, flush, re, clrErr};
    assign {ifC.inClear, ifC.inWriteEnable, ifC.inData, ifC.inPadFlush, ifC.inReadEnable, ifC.inClearErrors} = {clear, we, data, flush, re, clrErr};
    assign {ifD.inClear, ifD.inWriteEnable, ifD.inData, ifD.inPadFlush, ifD.inReadEnable, ifD.inClearErrors} = {clear, we, data, flush, re, clrErr};

    gear_fifo #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(7), .MSB_FIRST(1'b1), .EDGE_MODE(1'b0))
        dutA (.inClock(inClock), .inReset(inReset), .bus(ifA.slave));
    gear_fifo #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(7), .MSB_FIRST(1'b0), .EDGE_MODE(1'b0))
        dutB (.inClock(inClock), .inReset(inReset), .bus(ifB.slave));
    gear_fifo #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(2), .MSB_FIRST(1'b1), .EDGE_MODE(1'b0))
        dutC (.inClock(inClock), .inReset(inReset), .bus(ifC.slave));
    gear_fifo #(.IN_WIDTH(1), .OUT_WIDTH(8), .DEPTH_LOG2(7), .MSB_FIRST(1'b1), .EDGE_MODE(1'b1))
        dutD (.inClock(inClock), .inReset(inReset), .bus(ifD.slave));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge(s); outputs are sampled and inputs driven there.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge inClock);
            #1;
        end
    endtask

    task automatic doReset();
        {clear, we, data, flush, re, clrErr} = '0;
        inReset = 1'b1;
        step(2);
        inReset = 1'b0;
    endtask

    // Level-mode write of one word, sent MSB first, one chunk per cycle.
    task automatic writeWordLevel(input logic [7:0] word);
        for (int i = 7; i >= 0; i--) begin
            we   = 1'b1;
            data = word[i];
            step();
        end
        we = 1'b0;
    endtask

    // Edge-mode write: each chunk needs its own rising edge on the enable.
    task automatic writeWordEdge(input logic [7:0] word);
        for (int i = 7; i >= 0; i--) begin
            we   = 1'b1;
            data = word[i];
            step();
            we   = 1'b0;
            step();
        end
    endtask

    initial begin
        logic [7:0] pattern;
        logic [7:0] extra;
        int         validPulses;

        // ---------------- reset values ----------------
        doReset();
        check("rst.data",        ifA.outData, 8'h00);
        check("rst.readValid",   ifA.outReadValid, 1'b0);
        check("rst.readReady",   ifA.outReadReady, 1'b1);
        check("rst.level",       ifA.outLevel, 0);
        check("rst.partial",     ifA.outPartialCount, 0);
        check("rst.empty",       ifA.outEmpty, 1'b1);
        check("rst.almostEmpty", ifA.outAlmostEmpty, 1'b1);
        check("rst.full",        ifA.outFull, 1'b0);
        check("rst.almostFull",  ifA.outAlmostFull, 1'b0);
        check("rst.writeError",  ifA.outWriteError, 1'b0);
        check("rst.readError",   ifA.outReadError, 1'b0);

        // ---------------- bit packing, both orders ----------------
        pattern = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            we   = 1'b1;
            data = pattern[7 - i];
            step();
            if (i == 2) check("pack.partial3", ifA.outPartialCount, 3);
        end
        we = 1'b0;
        check("pack.levelA",   ifA.outLevel, 1);
        check("pack.partial0", ifA.outPartialCount, 0);
        check("pack.empty",    ifA.outEmpty, 1'b0);
        check("pack.levelB",   ifB.outLevel, 1);

        re = 1'b1;
        step();
        re = 1'b0;
        check("read.levelDrop",  ifA.outLevel, 0);
        check("read.noValidT1",  ifA.outReadValid, 1'b0);
        check("read.busyT1",     ifA.outReadReady, 1'b0);
        step();
        check("read.validT2",    ifA.outReadValid, 1'b1);
        check("read.msbData",    ifA.outData, 8'hB2);
        check("read.lsbData",    ifB.outData, 8'h4D);
        check("read.lsbValid",   ifB.outReadValid, 1'b1);
        step();
        check("read.readyT3",    ifA.outReadReady, 1'b1);
        check("read.validDrop",  ifA.outReadValid, 1'b0);

        // ---------------- pad flush ----------------
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.emptyNoop",  ifA.outLevel, 0);
        check("flush.emptyNoErr", ifA.outWriteError, 1'b0);
        for (int i = 0; i < 3; i++) begin
            we   = 1'b1;
            data = 1'b1;
            step();
        end
        we = 1'b0;
        check("flush.partial3", ifA.outPartialCount, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.level",   ifA.outLevel, 1);
        check("flush.partial", ifA.outPartialCount, 0);
        re = 1'b1;
        step();
        re = 1'b0;
        step();
        check("flush.valid", ifA.outReadValid, 1'b1);
        check("flush.data",  ifA.outData, 8'hE0);
        step();

        // ---------------- full FIFO (DEPTH = 4) ----------------
        doReset();
        writeWordLevel(8'hA1);
        writeWordLevel(8'h52);
        writeWordLevel(8'h37);
        writeWordLevel(8'hC4);
        check("full.level4",      ifC.outLevel, 4);
        check("full.full",        ifC.outFull, 1'b1);
        check("full.almostFull",  ifC.outAlmostFull, 1'b1);
        check("full.almostEmpty", ifC.outAlmostEmpty, 1'b0);
        check("full.noErrYet",    ifC.outWriteError, 1'b0);
        extra = 8'h5F;
        for (int i = 7; i >= 1; i--) begin
            we   = 1'b1;
            data = extra[i];
            step();
        end
        check("full.partial7",   ifC.outPartialCount, 7);
        check("full.noErr7",     ifC.outWriteError, 1'b0);
        data = extra[0];
        step();
        we = 1'b0;
        check("full.writeError", ifC.outWriteError, 1'b1);
        check("full.keepPart",   ifC.outPartialCount, 7);
        check("full.keepLevel",  ifC.outLevel, 4);
        check("full.stillFull",  ifC.outFull, 1'b1);
        we   = 1'b1;
        data = extra[0];
        re   = 1'b1;
        step();
        we = 1'b0;
        re = 1'b0;
        check("full.rdwrLevel",   ifC.outLevel, 4);
        check("full.rdwrPartial", ifC.outPartialCount, 0);
        check("full.errSticky",   ifC.outWriteError, 1'b1);
        step();
        check("full.readValid",   ifC.outReadValid, 1'b1);
        check("full.readOldest",  ifC.outData, 8'hA1);
        step();

        // ---------------- edge mode ----------------
        doReset();
        re = 1'b1;
        step();
        re = 1'b0;
        check("edge.emptyReadErr", ifD.outReadError, 1'b1);
        step();
        check("edge.noValid1", ifD.outReadValid, 1'b0);
        step();
        check("edge.noValid2", ifD.outReadValid, 1'b0);
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        check("edge.clearErr", ifD.outReadError, 1'b0);
        re     = 1'b1;
        clrErr = 1'b1;
        step();
        re = 1'b0;
        check("edge.errWins", ifD.outReadError, 1'b1);
        step();
        clrErr = 1'b0;
        check("edge.clearAgain", ifD.outReadError, 1'b0);

        writeWordEdge(8'h3C);
        writeWordEdge(8'h96);
        check("edge.level2", ifD.outLevel, 2);
        we   = 1'b1;
        data = 1'b1;
        step(3);
        we = 1'b0;
        step();
        check("edge.heldWrite", ifD.outPartialCount, 1);

        validPulses = 0;
        re = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ifD.outReadValid) validPulses++;
        end
        re = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ifD.outReadValid) validPulses++;
        end
        check("edge.oneRead",   validPulses, 1);
        check("edge.levelLeft", ifD.outLevel, 1);
        check("edge.readData",  ifD.outData, 8'h3C);
        check("edge.noHoldErr", ifD.outReadError, 1'b0);

        // ---------------- reset during a read ----------------
        doReset();
        writeWordLevel(8'h81);
        writeWordLevel(8'h42);
        writeWordLevel(8'h24);
        re = 1'b1;
        step();
        re = 1'b0;
        step();
        check("midrst.firstData", ifA.outData, 8'h81);
        step();
        re = 1'b1;
        step();
        re = 1'b0;
        check("midrst.inFetch", ifA.outReadReady, 1'b0);
        inReset = 1'b1;
        step();
        inReset = 1'b0;
        check("midrst.valid",   ifA.outReadValid, 1'b0);
        check("midrst.data",    ifA.outData, 8'h00);
        check("midrst.ready",   ifA.outReadReady, 1'b1);
        check("midrst.level",   ifA.outLevel, 0);
        check("midrst.partial", ifA.outPartialCount, 0);
        check("midrst.empty",   ifA.outEmpty, 1'b1);
        re = 1'b1;
        step();
        re = 1'b0;
        check("midrst.readErr", ifA.outReadError, 1'b1);
        step(2);
        check("midrst.noValid", ifA.outReadValid, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
